tx_trn_arbiter: RTL and testbench

TX_TRN_ARBITER -- requirements
Module: tx_trn_arbiter

---
 rtl/tx_arb_pkg.sv | 32 +++
 rtl/tx_trn_arbiter_rr_ptr.sv | 37 +++
 rtl/tx_trn_arbiter.sv | 160 ++++++++++++++++
 tb/tb_tx_trn_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared definitions for the TRN transmit arbiter: FSM state encoding,
// idle values driven onto the TRN TX port, and TLP header field constants.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2,
    ST_BUSY  = 2'd3
  } arb_state_e;

  // Values presented to the PCIe core when no requester owns the port
  localparam logic [63:0] TRN_TD_IDLE     = 64'h0;
  localparam logic [7:0]  TRN_TREM_N_IDLE = 8'hFF;
  localparam logic        TRN_CTRL_N_IDLE = 1'b1;

  // TLP fmt field (header length / data presence)
  localparam logic [1:0] TLP_FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] TLP_FMT_4DW_NODATA = 2'b01;
  localparam logic [1:0] TLP_FMT_3DW_DATA   = 2'b10;
  localparam logic [1:0] TLP_FMT_4DW_DATA   = 2'b11;

  // TLP type field
  localparam logic [4:0] TLP_TYPE_MEM    = 5'b00000;
  localparam logic [4:0] TLP_TYPE_MEM_LK = 5'b00001;
  localparam logic [4:0] TLP_TYPE_IO     = 5'b00010;
  localparam logic [4:0] TLP_TYPE_CPL    = 5'b01010;

  // Width of the window counter; large enough for the largest legal window
  localparam int WIN_CNT_W = 4;

endpackage

// File: rtl/tx_trn_arbiter_rr_ptr.sv
// Round-robin pointer register: clears to requester 0, advances by one
// and wraps from N-1 back to 0.
module rr_ptr #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         adv_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  // Next pointer: clear has priority over advance
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (adv_i) begin
      ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
    end
  end

  // Pointer register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/tx_trn_arbiter.sv
// Round-robin arbiter sharing one TRN transmit port between NUM_REQ
// requesters. Each requester is offered the port (my_turn) for
// TURN_WINDOW cycles plus one guard cycle in which a late acceptance is
// still honoured. Ownership is held for as long as driving_interface of
// the current requester stays high, so TLPs are never cut.
module tx_trn_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TURN_WINDOW = 4
) (
  input  logic                       trn_clk,
  input  logic                       reset_n,
  input  logic [64*NUM_REQ-1:0]      req_td,
  input  logic [8*NUM_REQ-1:0]       req_trem_n,
  input  logic [NUM_REQ-1:0]         req_tsof_n,
  input  logic [NUM_REQ-1:0]         req_teof_n,
  input  logic [NUM_REQ-1:0]         req_tsrc_rdy_n,
  input  logic [NUM_REQ-1:0]         driving_interface,
  output logic [NUM_REQ-1:0]         my_turn,
  output logic [63:0]                trn_td,
  output logic [7:0]                 trn_trem_n,
  output logic                       trn_tsof_n,
  output logic                       trn_teof_n,
  output logic                       trn_tsrc_rdy_n,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       arb_proto_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic                 proto_err_q, proto_err_d;
  logic [PTR_W-1:0]     ptr;
  logic                 ptr_adv;
  logic                 ptr_clr;
  logic [NUM_REQ-1:0]   ptr_onehot;
  logic                 drv_cur;
  logic                 drv_viol;

  rr_ptr #(
    .N (NUM_REQ),
    .W (PTR_W)
  ) u_rr_ptr (
    .clk_i   (trn_clk),
    .rst_n_i (reset_n),
    .clr_i   (ptr_clr),
    .adv_i   (ptr_adv),
    .ptr_o   (ptr)
  );

  // Decode the pointer and pick out the current requester's ownership bit
  always_comb begin
    ptr_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ptr == PTR_W'(i)) begin
        ptr_onehot[i] = 1'b1;
      end
    end
    drv_cur = |(driving_interface & ptr_onehot);
  end

  // Any requester driving while not pointed at (or while idle) is a violation
  always_comb begin
    if (state_q == ST_IDLE) begin
      drv_viol = |driving_interface;
    end else begin
      drv_viol = |(driving_interface & ~ptr_onehot);
    end
    proto_err_d = proto_err_q | drv_viol;
  end

  // Next-state logic: offer window, guard cycle, and ownership hold
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    ptr_adv   = 1'b0;
    ptr_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d   = ST_GRANT;
        win_cnt_d = '0;
        ptr_clr   = 1'b1;
      end
      ST_GRANT: begin
        if (drv_cur) begin
          state_d = ST_BUSY;
        end else if (win_cnt_q == WIN_CNT_W'(TURN_WINDOW - 1)) begin
          state_d = ST_GUARD;
        end else begin
          win_cnt_d = win_cnt_q + WIN_CNT_W'(1);
        end
      end
      ST_GUARD: begin
        // Requester saw my_turn on the final grant cycle and answered now
        if (drv_cur) begin
          state_d = ST_BUSY;
        end else begin
          state_d   = ST_GRANT;
          win_cnt_d = '0;
          ptr_adv   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!drv_cur) begin
          state_d   = ST_GRANT;
          win_cnt_d = '0;
          ptr_adv   = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        win_cnt_d = '0;
      end
    endcase
  end

  // State, window counter and sticky error registers
  always_ff @(posedge trn_clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      win_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Offer decoded purely from registered state and pointer
  always_comb begin
    my_turn = (state_q == ST_GRANT) ? ptr_onehot : '0;
  end

  // TRN transmit mux: pass through the owning requester, otherwise idle
  always_comb begin
    trn_td         = TRN_TD_IDLE;
    trn_trem_n     = TRN_TREM_N_IDLE;
    trn_tsof_n     = TRN_CTRL_N_IDLE;
    trn_teof_n     = TRN_CTRL_N_IDLE;
    trn_tsrc_rdy_n = TRN_CTRL_N_IDLE;
    if (state_q != ST_IDLE && drv_cur) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ptr_onehot[i]) begin
          trn_td         = req_td[64*i +: 64];
          trn_trem_n     = req_trem_n[8*i +: 8];
          trn_tsof_n     = req_tsof_n[i];
          trn_teof_n     = req_teof_n[i];
          trn_tsrc_rdy_n = req_tsrc_rdy_n[i];
        end
      end
    end
  end

  assign owner         = ptr;
  assign arb_proto_err = proto_err_q;

endmodule

// File: tb/tb_tx_trn_arbiter.sv
// Randomized bench for tx_trn_arbiter with a cycle-level reference model
// expressed as "offer age" and "busy owner" rather than FSM states.
module tb_tx_trn_arbiter;

  localparam int NR = 3;
  localparam int TW = 4;
  localparam int PW = $clog2(NR);

  logic              trn_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [64*NR-1:0]  req_td = '0;
  logic [8*NR-1:0]   req_trem_n = '1;
  logic [NR-1:0]     req_tsof_n = '1;
  logic [NR-1:0]     req_teof_n = '1;
  logic [NR-1:0]     req_tsrc_rdy_n = '1;
  logic [NR-1:0]     driving_interface = '0;
  logic [NR-1:0]     my_turn;
  logic [63:0]       trn_td;
  logic [7:0]        trn_trem_n;
  logic              trn_tsof_n;
  logic              trn_teof_n;
  logic              trn_tsrc_rdy_n;
  logic [PW-1:0]     owner;
  logic              arb_proto_err;

  always #5 trn_clk = ~trn_clk;

  tx_trn_arbiter #(
    .NUM_REQ     (NR),
    .TURN_WINDOW (TW)
  ) dut (
    .trn_clk           (trn_clk),
    .reset_n           (reset_n),
    .req_td            (req_td),
    .req_trem_n        (req_trem_n),
    .req_tsof_n        (req_tsof_n),
    .req_teof_n        (req_teof_n),
    .req_tsrc_rdy_n    (req_tsrc_rdy_n),
    .driving_interface (driving_interface),
    .my_turn           (my_turn),
    .trn_td            (trn_td),
    .trn_trem_n        (trn_trem_n),
    .trn_tsof_n        (trn_tsof_n),
    .trn_teof_n        (trn_teof_n),
    .trn_tsrc_rdy_n    (trn_tsrc_rdy_n),
    .owner             (owner),
    .arb_proto_err     (arb_proto_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: idle after reset, else an offer of age 0..TW to m_ptr
  // (age TW is the silent guard cycle) or a busy transfer by m_ptr.
  bit m_idle = 1'b1;
  int m_ptr  = 0;
  int m_age  = 0;
  bit m_busy = 1'b0;
  bit m_err  = 1'b0;
  bit rst_edge = 1'b0;

  // Requester behaviour
  bit hold  [NR];
  bit pend  [NR];
  bit first [NR];
  int beats [NR];
  int acc_pct = 0;
  int rst_cnt = 3;
  int rst_en  = 0;
  int viol_en = 0;

  function automatic logic [NR-1:0] exp_turn();
    logic [NR-1:0] t;
    t = '0;
    if (!m_idle && !m_busy && m_age < TW) t[m_ptr] = 1'b1;
    return t;
  endfunction

  task automatic check_cycle();
    logic [63:0] e_td;
    logic [7:0]  e_trem;
    logic [2:0]  e_fr;
    e_td   = 64'h0;
    e_trem = 8'hFF;
    e_fr   = 3'b111;
    if (!m_idle && driving_interface[m_ptr]) begin
      e_td   = req_td[64*m_ptr +: 64];
      e_trem = req_trem_n[8*m_ptr +: 8];
      e_fr   = {req_tsof_n[m_ptr], req_teof_n[m_ptr], req_tsrc_rdy_n[m_ptr]};
    end
    chk("my_turn", 64'(my_turn), 64'(exp_turn()));
    chk("trn_td", trn_td, e_td);
    chk("trn_trem_n", 64'(trn_trem_n), 64'(e_trem));
    chk("trn_framing", 64'({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}), 64'(e_fr));
    chk("owner", 64'(owner), 64'(m_ptr));
    chk("arb_proto_err", 64'(arb_proto_err), 64'(m_err));
  endtask

  task automatic model_edge();
    logic [NR-1:0] oh;
    rst_edge = !reset_n;
    if (!reset_n) begin
      m_idle = 1'b1; m_ptr = 0; m_age = 0; m_busy = 1'b0; m_err = 1'b0;
      return;
    end
    oh = '0;
    oh[m_ptr] = 1'b1;
    if (m_idle ? (|driving_interface) : (|(driving_interface & ~oh))) m_err = 1'b1;
    if (m_idle) begin
      m_idle = 1'b0; m_ptr = 0; m_age = 0;
    end else if (m_busy) begin
      if (!driving_interface[m_ptr]) begin
        m_busy = 1'b0; m_ptr = (m_ptr + 1) % NR; m_age = 0;
      end
    end else if (driving_interface[m_ptr]) begin
      m_busy = 1'b1;
    end else if (m_age == TW) begin
      m_ptr = (m_ptr + 1) % NR; m_age = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic drive_next();
    int j;
    for (int i = 0; i < NR; i++) begin
      if (rst_edge) begin hold[i] = 1'b0; pend[i] = 1'b0; end
      if (pend[i]) begin
        hold[i] = 1'b1; pend[i] = 1'b0; beats[i] = $urandom_range(1, 6); first[i] = 1'b1;
      end else if (hold[i] && beats[i] == 0) begin
        hold[i] = 1'b0;
      end
      req_td[64*i +: 64]   = {$urandom, $urandom};
      req_trem_n[8*i +: 8] = 8'($urandom);
      if (hold[i]) begin
        driving_interface[i] = 1'b1;
        if ($urandom_range(0, 3) != 0) begin
          req_tsrc_rdy_n[i] = 1'b0;
          req_tsof_n[i]     = !first[i];
          req_teof_n[i]     = (beats[i] != 1);
          beats[i]--;
          first[i] = 1'b0;
        end else begin
          req_tsrc_rdy_n[i] = 1'b1; req_tsof_n[i] = 1'b1; req_teof_n[i] = 1'b1;
        end
      end else begin
        driving_interface[i] = 1'b0;
        {req_tsof_n[i], req_teof_n[i], req_tsrc_rdy_n[i]} = 3'($urandom);
      end
    end
    if (viol_en != 0 && $urandom_range(0, 99) < 3) begin
      j = $urandom_range(0, NR - 1);
      if (!hold[j] && (m_idle || j != m_ptr)) driving_interface[j] = 1'b1;
    end
    if (rst_cnt > 0) begin
      reset_n = 1'b0;
      rst_cnt--;
    end else begin
      reset_n = 1'b1;
      if (rst_en != 0 && $urandom_range(0, 249) == 0) rst_cnt = $urandom_range(1, 3);
    end
  endtask

  // One clock: check at the falling edge, let requesters react to the
  // offer, advance the model, then drive new inputs after the rising edge.
  task automatic cycle(input bit do_check, input int seq_exp);
    logic [NR-1:0] t;
    @(negedge trn_clk);
    if (do_check) check_cycle();
    if (seq_exp >= 0) chk("offer_seq", 64'(my_turn), 64'(seq_exp));
    t = exp_turn();
    for (int i = 0; i < NR; i++) begin
      if (t[i] && !hold[i] && !pend[i] && $urandom_range(0, 99) < acc_pct) pend[i] = 1'b1;
    end
    model_edge();
    @(posedge trn_clk);
    #1;
    drive_next();
  endtask

  int seq_tbl [17] = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 4, 4, 4, 4, 0, 1};

  initial begin
    for (int i = 0; i < NR; i++) begin
      hold[i] = 1'b0; pend[i] = 1'b0; first[i] = 1'b0; beats[i] = 0;
    end
    // Reset, then idle rotation with nobody accepting
    for (int k = 0; k < 4; k++) cycle(k > 0, -1);
    for (int k = 0; k < 17; k++) cycle(1'b1, seq_tbl[k]);
    // Everyone accepts immediately: back-to-back hand-offs
    acc_pct = 100;
    for (int k = 0; k < 300; k++) cycle(1'b1, -1);
    // Mixed acceptance, including last-cycle acceptance, and random resets
    acc_pct = 25;
    rst_en  = 1;
    for (int k = 0; k < 2500; k++) cycle(1'b1, -1);
    // Protocol violations layered on top
    viol_en = 1;
    for (int k = 0; k < 2500; k++) cycle(1'b1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
